wasm_stack_core: RTL and testbench

//  Parametrised next-generation WASM stack CPU: fetches bytecode over the shared byte-wide memory port,

---
 rtl/wasm_stack_core_pkg.sv | 54 +++++
 rtl/wasm_stack_core_leb128.sv | 48 ++++
 rtl/wasm_stack_core.sv | 224 ++++++++++++++++++++++
 tb/tb_wasm_stack_core.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wasm_stack_core_pkg.sv
// Shared types, opcodes, trap codes and ALU helper for the WASM stack core.
package wasm_stack_core_pkg;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_IMM   = 3'd2,
    ST_FTAB  = 3'd3,
    ST_EXEC  = 3'd4,
    ST_HALT  = 3'd5
  } state_t;

  localparam logic [7:0] OP_UNREACH = 8'h00;
  localparam logic [7:0] OP_NOP     = 8'h01;
  localparam logic [7:0] OP_END     = 8'h0B;
  localparam logic [7:0] OP_CALL    = 8'h10;
  localparam logic [7:0] OP_DROP    = 8'h1A;
  localparam logic [7:0] OP_CONST   = 8'h41;
  localparam logic [7:0] OP_ADD     = 8'h6A;
  localparam logic [7:0] OP_SUB     = 8'h6B;
  localparam logic [7:0] OP_MUL     = 8'h6C;
  localparam logic [7:0] OP_AND     = 8'h71;
  localparam logic [7:0] OP_OR      = 8'h72;
  localparam logic [7:0] OP_XOR     = 8'h73;

  localparam logic [2:0] TRAP_NONE     = 3'd0;
  localparam logic [2:0] TRAP_UNREACH  = 3'd1;
  localparam logic [2:0] TRAP_OP_OVF   = 3'd2;
  localparam logic [2:0] TRAP_OP_UNF   = 3'd3;
  localparam logic [2:0] TRAP_CALL_OVF = 3'd4;
  localparam logic [2:0] TRAP_BAD_OP   = 3'd5;
  localparam logic [2:0] TRAP_LEB_LONG = 3'd6;
  localparam logic [2:0] TRAP_IMPORT   = 3'd7;

  localparam int FTAB_ENTRY_BYTES = 5;
  localparam int FLAG_SERVICE     = 0;
  localparam int FLAG_IMPORT      = 1;

  function automatic logic [31:0] alu32(input logic [7:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_MUL:  r = a * b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wasm_stack_core_leb128.sv
// Signed LEB128 accumulator: one byte per i_valid, reports completion, sign-extended value and overlength.
module wasm_stack_core_leb128 #(
  parameter int LEB_MAX = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_value,
  output logic        o_done,
  output logic        o_ovf
);
  localparam int CW = $clog2(LEB_MAX) + 1;

  logic [CW-1:0] r_cnt;
  logic [31:0]   r_acc;
  logic [31:0]   w_shift;
  logic [31:0]   w_mask;

  // Value including the byte currently presented; mask covers every bit above it.
  always_comb begin
    w_shift = {25'd0, i_byte[6:0]} << (32'd7 * 32'(r_cnt));
    w_mask  = ~((32'd1 << (32'd7 * (32'(r_cnt) + 32'd1))) - 32'd1);
    if (i_byte[6]) begin
      o_value = r_acc | w_shift | w_mask;
    end else begin
      o_value = r_acc | w_shift;
    end
  end

  assign o_done = i_valid & ~i_byte[7];
  assign o_ovf  = i_valid & i_byte[7] & (r_cnt == CW'(LEB_MAX - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_acc <= 32'd0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_acc <= 32'd0;
    end else if (i_valid && i_byte[7]) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= r_acc | w_shift;
    end
  end

endmodule

// File: rtl/wasm_stack_core.sv
// WASM stack CPU: byte-wide 4-phase fetch, LEB128 immediates, function-table calls,
// internal operand/call stacks and trap reporting.
module wasm_stack_core
  import wasm_stack_core_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter int          ADDR_W     = 32,
  parameter int          OP_DEPTH   = 16,
  parameter int          CALL_DEPTH = 8,
  parameter logic [31:0] FTAB_BASE  = 32'h0,
  parameter int          LEB_MAX    = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_access,
  output logic [ADDR_W-1:0]         addr,
  output logic [7:0]                data_in,
  input  logic [7:0]                data_out,
  output logic                      memory_read_en,
  output logic                      memory_write_en,
  input  logic                      memory_ready,
  input  logic                      rom_mapped,
  input  logic [31:0]               first_instruction,
  output logic                      halted,
  output logic [2:0]                trap,
  output logic [ADDR_W-1:0]         pc_o,
  output logic [$clog2(OP_DEPTH):0] op_depth
);
  localparam int SPW = $clog2(OP_DEPTH);
  localparam int CPW = $clog2(CALL_DEPTH);

  state_t            r_state;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_pc;
  logic [7:0]        r_op;
  logic [7:0]        r_flags;
  logic [31:0]       r_imm;
  logic [31:0]       r_tgt;
  logic [2:0]        r_fidx;
  logic              r_halted;
  logic [2:0]        r_trap;
  logic [DATA_W-1:0] r_op_stk [OP_DEPTH];
  logic [SPW:0]      r_sp;
  logic [ADDR_W-1:0] r_call_stk [CALL_DEPTH];
  logic [CPW:0]      r_csp;

  logic              w_fetching;
  logic              w_can_issue;
  logic              w_rd_done;
  logic              w_leb_done;
  logic              w_leb_ovf;
  logic [31:0]       w_leb_value;
  logic [ADDR_W-1:0] w_ftab_addr;
  logic [SPW-1:0]    w_i1;
  logic [SPW-1:0]    w_i2;
  logic [CPW-1:0]    w_ci1;
  logic [31:0]       w_a;
  logic [31:0]       w_b;

  // A new request waits for the previous ready to fall and for the grant.
  assign w_fetching  = (r_state == ST_FETCH) || (r_state == ST_IMM) || (r_state == ST_FTAB);
  assign w_can_issue = w_fetching && !r_rd_en && !memory_ready && mem_access;
  assign w_rd_done   = r_rd_en && memory_ready && mem_access;
  assign w_ftab_addr = ADDR_W'(FTAB_BASE) + ADDR_W'(r_imm) * ADDR_W'(FTAB_ENTRY_BYTES)
                       + ADDR_W'(r_fidx);
  assign w_i1  = SPW'(r_sp - 1'b1);
  assign w_i2  = SPW'(r_sp - 2'd2);
  assign w_ci1 = CPW'(r_csp - 1'b1);
  assign w_a   = r_op_stk[w_i2][31:0];
  assign w_b   = r_op_stk[w_i1][31:0];

  assign addr            = r_addr;
  assign data_in         = 8'd0;
  assign memory_read_en  = r_rd_en;
  assign memory_write_en = 1'b0;
  assign halted          = r_halted;
  assign trap            = r_trap;
  assign pc_o            = r_pc;
  assign op_depth        = r_sp;

  wasm_stack_core_leb128 #(.LEB_MAX(LEB_MAX)) u_leb (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (r_state == ST_FETCH),
    .i_valid (w_rd_done && (r_state == ST_IMM)),
    .i_byte  (data_out),
    .o_value (w_leb_value),
    .o_done  (w_leb_done),
    .o_ovf   (w_leb_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_BOOT;
      r_rd_en  <= 1'b0;
      r_addr   <= '0;
      r_pc     <= '0;
      r_op     <= 8'd0;
      r_flags  <= 8'd0;
      r_imm    <= 32'd0;
      r_tgt    <= 32'd0;
      r_fidx   <= 3'd0;
      r_halted <= 1'b0;
      r_trap   <= TRAP_NONE;
      r_sp     <= '0;
      r_csp    <= '0;
      for (int i = 0; i < OP_DEPTH; i++) r_op_stk[i] <= '0;
      for (int i = 0; i < CALL_DEPTH; i++) r_call_stk[i] <= '0;
    end else begin
      if (w_can_issue) begin
        r_rd_en <= 1'b1;
        r_addr  <= (r_state == ST_FTAB) ? w_ftab_addr : r_pc;
      end
      if (w_rd_done) begin
        r_rd_en <= 1'b0;
      end
      case (r_state)
        ST_BOOT: begin
          if (rom_mapped) begin
            r_pc    <= ADDR_W'(first_instruction);
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (w_rd_done) begin
            r_op    <= data_out;
            r_pc    <= r_pc + 1'b1;
            r_state <= (data_out == OP_CONST || data_out == OP_CALL) ? ST_IMM : ST_EXEC;
          end
        end
        ST_IMM: begin
          if (w_rd_done) begin
            r_pc <= r_pc + 1'b1;
            if (w_leb_ovf) begin
              r_trap <= TRAP_LEB_LONG; r_halted <= 1'b1; r_state <= ST_HALT;
            end else if (w_leb_done) begin
              r_imm   <= w_leb_value;
              r_fidx  <= 3'd0;
              r_state <= (r_op == OP_CALL) ? ST_FTAB : ST_EXEC;
            end
          end
        end
        // Entry bytes 0-3 shift in little-endian; byte 4 carries the flags.
        ST_FTAB: begin
          if (w_rd_done) begin
            r_fidx <= r_fidx + 1'b1;
            if (r_fidx == 3'd4) begin
              r_flags <= data_out;
              r_state <= ST_EXEC;
            end else begin
              r_tgt <= {data_out, r_tgt[31:8]};
            end
          end
        end
        ST_EXEC: begin
          r_state <= ST_FETCH;
          case (r_op)
            OP_UNREACH: begin
              r_trap <= TRAP_UNREACH; r_halted <= 1'b1; r_state <= ST_HALT;
            end
            OP_NOP: begin
              r_state <= ST_FETCH;
            end
            OP_END: begin
              if (r_csp == '0) begin
                r_halted <= 1'b1; r_state <= ST_HALT;
              end else begin
                r_pc  <= r_call_stk[w_ci1];
                r_csp <= r_csp - 1'b1;
              end
            end
            OP_CALL: begin
              if (r_flags[FLAG_IMPORT] || r_flags[FLAG_SERVICE]) begin
                r_trap <= TRAP_IMPORT; r_halted <= 1'b1; r_state <= ST_HALT;
              end else if (32'(r_sp) < 32'(r_flags[7:2])) begin
                r_trap <= TRAP_OP_UNF; r_halted <= 1'b1; r_state <= ST_HALT;
              end else if (r_csp == (CPW+1)'(CALL_DEPTH)) begin
                r_trap <= TRAP_CALL_OVF; r_halted <= 1'b1; r_state <= ST_HALT;
              end else begin
                r_call_stk[r_csp[CPW-1:0]] <= r_pc;
                r_csp <= r_csp + 1'b1;
                r_pc  <= ADDR_W'(r_tgt);
              end
            end
            OP_DROP: begin
              if (r_sp == '0) begin
                r_trap <= TRAP_OP_UNF; r_halted <= 1'b1; r_state <= ST_HALT;
              end else begin
                r_sp <= r_sp - 1'b1;
              end
            end
            OP_CONST: begin
              if (r_sp == (SPW+1)'(OP_DEPTH)) begin
                r_trap <= TRAP_OP_OVF; r_halted <= 1'b1; r_state <= ST_HALT;
              end else begin
                r_op_stk[r_sp[SPW-1:0]] <= DATA_W'(r_imm);
                r_sp <= r_sp + 1'b1;
              end
            end
            OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR: begin
              if (r_sp < (SPW+1)'(2)) begin
                r_trap <= TRAP_OP_UNF; r_halted <= 1'b1; r_state <= ST_HALT;
              end else begin
                r_op_stk[w_i2] <= DATA_W'(alu32(r_op, w_a, w_b));
                r_sp <= r_sp - 1'b1;
              end
            end
            default: begin
              r_trap <= TRAP_BAD_OP; r_halted <= 1'b1; r_state <= ST_HALT;
            end
          endcase
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state <= ST_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wasm_stack_core.sv
// Directed bench for wasm_stack_core with a 4-phase byte memory responder (DATA_W=64, OP_DEPTH=4).
module tb_wasm_stack_core;
  localparam int DATA_W     = 64;
  localparam int ADDR_W     = 32;
  localparam int OP_DEPTH   = 4;
  localparam int CALL_DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mem_access = 1'b1;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data_in;
  logic [7:0]        data_out;
  logic              memory_read_en;
  logic              memory_write_en;
  logic              memory_ready;
  logic              rom_mapped = 1'b0;
  logic [31:0]       first_instruction = 32'h100;
  logic              halted;
  logic [2:0]        trap;
  logic [ADDR_W-1:0] pc_o;
  logic [2:0]        op_depth;

  int   tests = 0;
  int   fails = 0;
  int   max_dly = 0;
  bit   toggle_en = 1'b0;
  int   dly_cnt;
  int   cur_dly;
  logic [7:0] mem [0:1023];

  wasm_stack_core #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_DEPTH(OP_DEPTH), .CALL_DEPTH(CALL_DEPTH),
    .FTAB_BASE(32'h0), .LEB_MAX(5)
  ) dut (
    .clk(clk), .rst(rst), .mem_access(mem_access), .addr(addr), .data_in(data_in),
    .data_out(data_out), .memory_read_en(memory_read_en), .memory_write_en(memory_write_en),
    .memory_ready(memory_ready), .rom_mapped(rom_mapped), .first_instruction(first_instruction),
    .halted(halted), .trap(trap), .pc_o(pc_o), .op_depth(op_depth)
  );

  always #5 clk = ~clk;

  // Memory responder: ready after a random delay, held until read_en drops.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      memory_ready <= 1'b0;
      data_out     <= 8'h00;
      dly_cnt      <= 0;
      cur_dly      <= 0;
    end else if (memory_read_en && !memory_ready) begin
      if (dly_cnt >= cur_dly) begin
        memory_ready <= 1'b1;
        data_out     <= mem[addr[9:0]];
        dly_cnt      <= 0;
        cur_dly      <= int'($urandom_range(0, max_dly));
      end else begin
        dly_cnt <= dly_cnt + 1;
      end
    end else if (!memory_read_en && memory_ready) begin
      memory_ready <= 1'b0;
    end
  end

  always @(negedge clk) mem_access = toggle_en ? ($urandom_range(0, 2) != 0) : 1'b1;

  task automatic prep(input logic [159:0] code, input int n);
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    for (int i = 0; i < n; i++) mem[256 + i] = code[8*(n-1-i) +: 8];
  endtask

  task automatic set_ftab(input logic [31:0] tgt, input logic [7:0] flags);
    mem[0] = tgt[7:0]; mem[1] = tgt[15:8]; mem[2] = tgt[23:16]; mem[3] = tgt[31:24];
    mem[4] = flags;
  endtask

  task automatic boot;
    rst = 1'b1; rom_mapped = 1'b0; first_instruction = 32'h100;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rom_mapped = 1'b1;
  endtask

  task automatic run_to_halt;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (halted) break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; rom_mapped = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({halted, trap, op_depth, memory_read_en, memory_write_en, data_in} !== 16'd0 ||
        addr !== 32'd0 || pc_o !== 32'd0) begin
      fails++;
      $display("FAIL reset_outputs: got halted=%0b trap=%0d depth=%0d rd=%0b addr=%h pc=%h, required all 0",
               halted, trap, op_depth, memory_read_en, addr, pc_o);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    tests++;
    if (memory_read_en !== 1'b0 || pc_o !== 32'd0) begin
      fails++;
      $display("FAIL boot_wait: got rd=%0b pc=%h, required rd=0 pc=0", memory_read_en, pc_o);
    end
  endtask

  task automatic test_add;
    prep(160'h41_05_41_03_6A_0B, 6); boot(); run_to_halt();
    tests++;
    if ({halted, trap, op_depth} !== {1'b1, 3'd0, 3'd1} || pc_o !== 32'h106) begin
      fails++;
      $display("FAIL add_status: got h=%0b t=%0d d=%0d pc=%h, required 1 0 1 106", halted, trap, op_depth, pc_o);
    end
    tests++;
    if (dut.r_op_stk[0] !== 64'd8) begin
      fails++; $display("FAIL add_top: got %h, required 8", dut.r_op_stk[0]);
    end
    repeat (20) @(negedge clk);
    tests++;
    if (halted !== 1'b1 || memory_read_en !== 1'b0 || pc_o !== 32'h106) begin
      fails++;
      $display("FAIL halt_sticky: got h=%0b rd=%0b pc=%h, required 1 0 106", halted, memory_read_en, pc_o);
    end
  endtask

  task automatic test_leb;
    prep(160'h41_7F_0B, 3); boot(); run_to_halt();
    tests++;
    if ({halted, trap, op_depth} !== {1'b1, 3'd0, 3'd1} || dut.r_op_stk[0] !== 64'h0000_0000_FFFF_FFFF) begin
      fails++;
      $display("FAIL leb_minus1: got t=%0d d=%0d top=%h, required 0 1 00000000ffffffff", trap, op_depth, dut.r_op_stk[0]);
    end
    prep(160'h41_E5_8E_26_41_C0_BB_78_0B, 9); boot(); run_to_halt();
    tests++;
    if ({halted, trap, op_depth} !== {1'b1, 3'd0, 3'd2} || pc_o !== 32'h109 ||
        dut.r_op_stk[0] !== 64'h98765 || dut.r_op_stk[1] !== 64'h0000_0000_FFFE_1DC0) begin
      fails++;
      $display("FAIL leb_multi: got t=%0d d=%0d pc=%h s0=%h s1=%h, required 0 2 109 98765 fffe1dc0",
               trap, op_depth, pc_o, dut.r_op_stk[0], dut.r_op_stk[1]);
    end
    prep(160'h41_80_80_80_80_80, 6); boot(); run_to_halt();
    tests++;
    if ({halted, trap, op_depth} !== {1'b1, 3'd6, 3'd0} || pc_o !== 32'h106) begin
      fails++;
      $display("FAIL leb_too_long: got t=%0d d=%0d pc=%h, required 6 0 106", trap, op_depth, pc_o);
    end
  endtask

  task automatic test_alu;
    prep(160'h41_06_41_07_6C_41_0F_71_41_05_72_41_03_73_01_41_09_1A_0B, 19); boot(); run_to_halt();
    tests++;
    if ({halted, trap, op_depth} !== {1'b1, 3'd0, 3'd1} || pc_o !== 32'h113 || dut.r_op_stk[0] !== 64'd12) begin
      fails++;
      $display("FAIL alu_chain: got t=%0d d=%0d pc=%h top=%h, required 0 1 113 c", trap, op_depth, pc_o, dut.r_op_stk[0]);
    end
    prep(160'h41_03_41_05_6B_0B, 6); boot(); run_to_halt();
    tests++;
    if ({halted, trap, op_depth} !== {1'b1, 3'd0, 3'd1} || dut.r_op_stk[0] !== 64'h0000_0000_FFFF_FFFE) begin
      fails++;
      $display("FAIL sub_wrap: got t=%0d top=%h, required 0 00000000fffffffe", trap, dut.r_op_stk[0]);
    end
  endtask

  task automatic test_call;
    prep(160'h41_01_10_00_0B, 5); set_ftab(32'h200, 8'h04);
    mem[512] = 8'h41; mem[513] = 8'h07; mem[514] = 8'h0B;
    boot(); run_to_halt();
    tests++;
    if ({halted, trap, op_depth} !== {1'b1, 3'd0, 3'd2} || pc_o !== 32'h105 ||
        dut.r_op_stk[0] !== 64'd1 || dut.r_op_stk[1] !== 64'd7) begin
      fails++;
      $display("FAIL call_return: got t=%0d d=%0d pc=%h s1=%h, required 0 2 105 7", trap, op_depth, pc_o, dut.r_op_stk[1]);
    end
  endtask

  task automatic test_call_faults;
    prep(160'h41_01_10_00_0B, 5); set_ftab(32'h200, 8'h06); boot(); run_to_halt();
    tests++;
    if ({halted, trap, op_depth} !== {1'b1, 3'd7, 3'd1} || pc_o !== 32'h104) begin
      fails++; $display("FAIL call_import: got t=%0d d=%0d pc=%h, required 7 1 104", trap, op_depth, pc_o);
    end
    prep(160'h41_01_10_00_0B, 5); set_ftab(32'h200, 8'h08); boot(); run_to_halt();
    tests++;
    if ({halted, trap, op_depth} !== {1'b1, 3'd3, 3'd1} || pc_o !== 32'h104) begin
      fails++; $display("FAIL call_params: got t=%0d d=%0d pc=%h, required 3 1 104", trap, op_depth, pc_o);
    end
    prep(160'h10_00, 2); set_ftab(32'h100, 8'h00); boot(); run_to_halt();
    tests++;
    if ({halted, trap, op_depth} !== {1'b1, 3'd4, 3'd0} || pc_o !== 32'h102) begin
      fails++; $display("FAIL call_overflow: got t=%0d d=%0d pc=%h, required 4 0 102", trap, op_depth, pc_o);
    end
  endtask

  task automatic test_stack_bounds;
    prep(160'h41_01_41_01_41_01_41_01_41_01, 10); boot(); run_to_halt();
    tests++;
    if ({halted, trap, op_depth} !== {1'b1, 3'd2, 3'd4} || pc_o !== 32'h10A) begin
      fails++; $display("FAIL op_overflow: got t=%0d d=%0d pc=%h, required 2 4 10a", trap, op_depth, pc_o);
    end
    prep(160'h41_01_41_01_41_01_41_01_6A_0B, 10); boot(); run_to_halt();
    tests++;
    if ({halted, trap, op_depth} !== {1'b1, 3'd0, 3'd3} || dut.r_op_stk[2] !== 64'd2) begin
      fails++; $display("FAIL full_binop: got t=%0d d=%0d s2=%h, required 0 3 2", trap, op_depth, dut.r_op_stk[2]);
    end
    prep(160'h6A, 1); boot(); run_to_halt();
    tests++;
    if ({halted, trap, op_depth} !== {1'b1, 3'd3, 3'd0} || pc_o !== 32'h101) begin
      fails++; $display("FAIL add_underflow: got t=%0d d=%0d pc=%h, required 3 0 101", trap, op_depth, pc_o);
    end
    prep(160'h1A, 1); boot(); run_to_halt();
    tests++;
    if ({halted, trap, op_depth} !== {1'b1, 3'd3, 3'd0}) begin
      fails++; $display("FAIL drop_underflow: got t=%0d d=%0d, required 3 0", trap, op_depth);
    end
  endtask

  task automatic test_bad_ops;
    prep(160'hFF, 1); boot(); run_to_halt();
    tests++;
    if ({halted, trap, op_depth} !== {1'b1, 3'd5, 3'd0} || pc_o !== 32'h101) begin
      fails++; $display("FAIL bad_opcode: got t=%0d pc=%h, required 5 101", trap, pc_o);
    end
    prep(160'h00, 1); boot(); run_to_halt();
    tests++;
    if ({halted, trap, op_depth} !== {1'b1, 3'd1, 3'd0}) begin
      fails++; $display("FAIL unreachable: got t=%0d, required 1", trap);
    end
  endtask

  task automatic test_back_to_back_stall;
    max_dly = 7; toggle_en = 1'b1;
    prep(160'h41_01_10_00_0B, 5); set_ftab(32'h200, 8'h04);
    mem[512] = 8'h41; mem[513] = 8'h07; mem[514] = 8'h0B;
    boot(); run_to_halt();
    tests++;
    if ({halted, trap, op_depth} !== {1'b1, 3'd0, 3'd2} || pc_o !== 32'h105 || dut.r_op_stk[1] !== 64'd7) begin
      fails++; $display("FAIL stall_call: got t=%0d d=%0d pc=%h s1=%h, required 0 2 105 7", trap, op_depth, pc_o, dut.r_op_stk[1]);
    end
    prep(160'h41_06_41_07_6C_41_0F_71_41_05_72_41_03_73_01_41_09_1A_0B, 19); boot(); run_to_halt();
    tests++;
    if ({halted, trap, op_depth} !== {1'b1, 3'd0, 3'd1} || pc_o !== 32'h113 || dut.r_op_stk[0] !== 64'd12) begin
      fails++; $display("FAIL stall_alu: got t=%0d d=%0d pc=%h top=%h, required 0 1 113 c", trap, op_depth, pc_o, dut.r_op_stk[0]);
    end
    max_dly = 0; toggle_en = 1'b0;
  endtask

  task automatic test_reset_mid_ftab;
    bit seen;
    seen = 1'b0;
    prep(160'h41_01_10_00_0B, 5); set_ftab(32'h200, 8'h04);
    mem[512] = 8'h41; mem[513] = 8'h07; mem[514] = 8'h0B;
    boot();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (memory_read_en && addr == 32'd2) begin
        seen = 1'b1;
        break;
      end
    end
    tests++;
    if (!seen) begin
      fails++; $display("FAIL ftab_reach: got no read at addr 2, required one");
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({halted, trap, op_depth, memory_read_en} !== 8'd0 || addr !== 32'd0 || pc_o !== 32'd0) begin
      fails++;
      $display("FAIL rst_mid_ftab: got h=%0b t=%0d d=%0d rd=%0b addr=%h pc=%h, required all 0",
               halted, trap, op_depth, memory_read_en, addr, pc_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_to_halt();
    tests++;
    if ({halted, trap, op_depth} !== {1'b1, 3'd0, 3'd2} || pc_o !== 32'h105 || dut.r_op_stk[1] !== 64'd7) begin
      fails++; $display("FAIL rerun_after_rst: got t=%0d d=%0d pc=%h s1=%h, required 0 2 105 7", trap, op_depth, pc_o, dut.r_op_stk[1]);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_leb();
    test_alu();
    test_call();
    test_call_faults();
    test_stack_bounds();
    test_bad_ops();
    test_back_to_back_stall();
    test_reset_mid_ftab();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
